// File: rtl/pipe_pkg.sv
// -----------------------------------------------------------------------------
// pipe_pkg
// Shared definitions for the processor pipeline stage buffers.
//   - Depth limit and statistics counter widths used by pipe_stage_buf.
//   - Packed stage-payload structs; callers size DATA_W with $bits(<type>).
// No ports (package).
// -----------------------------------------------------------------------------
package pipe_pkg;

    localparam int MAX_DEPTH   = 16;
    localparam int STALL_CNT_W = 32;
    localparam int FLUSH_CNT_W = 16;

    // Fetch -> decode
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } if_id_t;

    // Decode -> execute
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] rs1_val;
        logic [31:0] rs2_val;
        logic [31:0] imm;
        logic [4:0]  rd;
        logic [3:0]  alu_op;
        logic        mem_rd;
        logic        mem_wr;
        logic        reg_wr;
    } id_ex_t;

    // Execute -> memory
    typedef struct packed {
        logic [31:0] alu_res;
        logic [31:0] store_val;
        logic [4:0]  rd;
        logic        mem_rd;
        logic        mem_wr;
        logic        reg_wr;
    } ex_mem_t;

    // Memory -> writeback
    typedef struct packed {
        logic [31:0] wb_val;
        logic [4:0]  rd;
        logic        reg_wr;
    } mem_wb_t;

    // Pointer width for a circular buffer of the given depth (at least 1 bit).
    function automatic int ptr_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/pipe_stage_mem.sv
// -----------------------------------------------------------------------------
// pipe_stage_mem
// DEPTH x DATA_W register array backing pipe_stage_buf. One synchronous write
// port, one asynchronous read port. Contents are deliberately not reset.
// Ports:
//   clk      in   clock, rising edge
//   we_i     in   write enable
//   waddr_i  in   write slot index
//   wdata_i  in   write data
//   raddr_i  in   read slot index
//   rdata_o  out  contents of slot raddr_i
// -----------------------------------------------------------------------------
module pipe_stage_mem
    import pipe_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 2,
    parameter int PTR_W  = 1
) (
    input  logic              clk,
    input  logic              we_i,
    input  logic [PTR_W-1:0]  waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic [PTR_W-1:0]  raddr_i,
    output logic [DATA_W-1:0] rdata_o
);

    logic [DATA_W-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/pipe_stage_buf.sv
// -----------------------------------------------------------------------------
// pipe_stage_buf
// Elastic pipeline-stage register: a DEPTH-entry FIFO with valid/ready
// handshakes on both sides, plus freeze (stall) and flush (squash). When no
// entry is held, out_data shows NOP_VALUE so the next stage sees a bubble.
//
// Optional feature macro: PIPE_STAGE_STATS_EN adds the stall_cycles and
// flush_events statistics ports and counters.
//
// Ports:
//   clk           in   clock, rising edge
//   rst           in   asynchronous active-low reset
//   freeze        in   hold all state; blocks enqueue and dequeue
//   flush         in   discard all held entries at the next edge
//   in_valid      in   upstream offers in_data
//   in_ready      out  buffer accepts in_data this cycle
//   in_data       in   upstream payload
//   out_valid     out  out_data holds a real entry
//   out_ready     in   downstream consumes the head this cycle
//   out_data      out  head entry, or NOP_VALUE when empty
//   count         out  entries currently held
//   stall_cycles  out  (stats) cycles with in_valid && !in_ready, saturating
//   flush_events  out  (stats) flushes that discarded entries, saturating
// -----------------------------------------------------------------------------
module pipe_stage_buf
    import pipe_pkg::*;
#(
    parameter int                DATA_W    = 32,
    parameter int                DEPTH     = 2,
    parameter logic [DATA_W-1:0] NOP_VALUE = '0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       freeze,
    input  logic                       flush,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [DATA_W-1:0]          in_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [DATA_W-1:0]          out_data,
    output logic [$clog2(DEPTH+1)-1:0] count
`ifdef PIPE_STAGE_STATS_EN
   ,output logic [STALL_CNT_W-1:0]     stall_cycles
   ,output logic [FLUSH_CNT_W-1:0]     flush_events
`endif
);

    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int PTR_W = ptr_width(DEPTH);

    localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(DEPTH);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);

    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]  count_q,  count_d;
    logic [DATA_W-1:0] head_data;
    logic              push;
    logic              pop;

    // Explicit wrap so DEPTH need not be a power of two.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_LAST) ? '0 : p + 1'b1;
    endfunction

    // Neither handshake looks at the opposite side's handshake input, so
    // there is no combinational path from out_ready to in_ready (or back).
    assign in_ready  = (count_q < DEPTH_C) && !freeze && !flush;
    assign out_valid = (count_q != '0) && !freeze && !flush;

    assign push = in_valid && in_ready;
    assign pop  = out_valid && out_ready;

    assign out_data = (count_q != '0) ? head_data : NOP_VALUE;
    assign count    = count_q;

    pipe_stage_mem #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .PTR_W  (PTR_W)
    ) u_mem (
        .clk     (clk),
        .we_i    (push),
        .waddr_i (wr_ptr_q),
        .wdata_i (in_data),
        .raddr_i (rd_ptr_q),
        .rdata_o (head_data)
    );

    // Freeze needs no branch here: push and pop are already gated off by it.
    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = ptr_inc(wr_ptr_q);
            if (pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
            case ({push, pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

`ifdef PIPE_STAGE_STATS_EN
    logic [STALL_CNT_W-1:0] stall_q, stall_d;
    logic [FLUSH_CNT_W-1:0] flush_ev_q, flush_ev_d;

    always_comb begin
        stall_d    = stall_q;
        flush_ev_d = flush_ev_q;
        if (in_valid && !in_ready && (stall_q != '1)) begin
            stall_d = stall_q + 1'b1;
        end
        // Only flushes that actually squash something are interesting.
        if (flush && (count_q != '0) && (flush_ev_q != '1)) begin
            flush_ev_d = flush_ev_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_q    <= '0;
            flush_ev_q <= '0;
        end else begin
            stall_q    <= stall_d;
            flush_ev_q <= flush_ev_d;
        end
    end

    assign stall_cycles = stall_q;
    assign flush_events = flush_ev_q;
`endif

endmodule

// File: doc/pipe_stage_buf.md
# pipe_stage_buf

Parametrised elastic pipeline-stage register replacing the fixed per-stage registers (IF/ID/EXE/MEM) in the processor pipeline. It holds up to DEPTH payload words of DATA_W bits in FIFO order and moves them with a valid/ready handshake. It also supports freeze (stall) and flush (branch squash), so a stage boundary can absorb back-pressure instead of the whole pipeline freezing. When empty or flushed it presents a configurable bubble word.

## Interface
- DATA_W, 32, payload width in bits (packed control + data fields of one stage)
- DEPTH, 2, number of buffer slots, 1..16, not required to be a power of two
- NOP_VALUE, '0, DATA_W-bit word presented on out_data when no entry is held
- clk  in  1  single clock, rising edge
- rst  in  1  reset, asynchronous, active-low
- freeze  in  1  hold all state; blocks enqueue and dequeue
- flush  in  1  discard all held entries at next edge
- in_valid  in  1  upstream offers in_data
- in_ready  out  1  buffer accepts in_data this cycle
- in_data  in  DATA_W  upstream payload
- out_valid  out  1  out_data holds a real entry
- out_ready  in  1  downstream consumes head this cycle
- out_data  out  DATA_W  head entry, or NOP_VALUE when empty
- count  out  CNT_W = $clog2(DEPTH+1)  entries currently held
- stall_cycles  out  32  (PIPE_STAGE_STATS_EN only) upstream-blocked cycle count
- flush_events  out  16  (PIPE_STAGE_STATS_EN only) flushes that discarded ≥1 entry

## Operation
- Storage: circular array; rd_ptr and wr_ptr wrap from DEPTH-1 to 0 by explicit compare; count tracks occupancy.
- Enqueue when in_valid && in_ready; in_ready = (count < DEPTH) && !freeze && !flush. in_ready does not depend on out_ready (no combinational path from out_ready to in_ready).
- Dequeue when out_valid && out_ready; out_valid = (count != 0) && !freeze && !flush.
- Simultaneous enqueue and dequeue: count unchanged, both pointers advance.
- out_data = storage[rd_ptr] when count != 0, else NOP_VALUE. Driven from registers; no combinational path from in_data.
- Priority at each edge: flush > freeze > handshake.
  - flush: count←0, pointers←0; the same-cycle enqueue is dropped (in_ready is already 0).
  - freeze: no state change.
- Storage contents are not cleared by reset or flush. Only the pointers and count are cleared.
- Reset (rst low, async): count=0, pointers=0, so out_valid=0, out_data=NOP_VALUE, in_ready=1 after release (if not frozen/flushing), stats=0. Reset mid-transfer discards all entries immediately.

## Timing
- Latency: a word accepted at edge N appears on out_data after edge N (visible in cycle N+1). Minimum one cycle, no fall-through.
- Throughput:
  - DEPTH=1: at most one word every 2 cycles, because a full buffer refuses input while draining.
  - DEPTH≥2: one word per cycle sustained when out_ready is held high.
- Full (count==DEPTH): in_ready=0 for the whole cycle even if out_ready=1.
- Empty: out_valid=0; out_ready is ignored.
- freeze and flush take effect in the cycle they are high (combinational on in_ready/out_valid) and on the following edge.

## Configuration
- PIPE_STAGE_STATS_EN defined:
  - stall_cycles increments each cycle with in_valid && !in_ready (including freeze/flush cycles).
  - flush_events increments on each edge where flush is high and count != 0.
  - Both counters saturate at all-ones and reset to 0 on rst.
- PIPE_STAGE_STATS_EN undefined: stall_cycles and flush_events ports and their logic are absent. All other behaviour is identical.

## Structure
- Shared package pipe_pkg holds:
  - MAX_DEPTH=16, STALL_CNT_W=32, FLUSH_CNT_W=16
  - the packed stage-payload typedefs (if_id_t, id_ex_t, ex_mem_t, mem_wb_t) that callers size DATA_W from
- One sub-module, pipe_stage_mem: DEPTH×DATA_W register array, one write port, one async read port, no reset. Pointer/count control stays in pipe_stage_buf.

## Test plan
All scenarios use DATA_W=32 and DEPTH=2 unless stated.
- Reset then idle → out_valid=0, out_data=0, in_ready=1, count=0.
- Stream 0x11,0x22,0x33 with out_ready=1 on consecutive cycles → out_data 0x11,0x22,0x33 on the three cycles after each accept, with in_ready never dropping.
- out_ready=0, offer 0xA,0xB,0xC → 0xA,0xB accepted, count=2, in_ready=0 while 0xC is held upstream. Then out_ready=1 → 0xA out, 0xC accepted, order preserved.
- count=2, assert flush together with in_valid=1 (0xDD) → next cycle count=0, out_data=NOP_VALUE; 0xDD never appears; flush_events=1 when the macro is defined.
- count=1, freeze high for 3 cycles with in_valid=1, out_ready=1 → count stays 1, out_valid=0, stall_cycles=3. On release, head dequeues.
- DEPTH=1 with out_ready=1 and continuous in_valid → accepts on alternate cycles only; drop rst mid-stream → out_valid=0 immediately, without waiting for a clock edge.
